// File: rtl/ifu_fetch.sv
// ifu_fetch: single-outstanding instruction fetch unit.
//
// Issues one word-aligned fetch at a time to instruction memory, holds the
// returned word in a one-entry output buffer until decode takes it, and
// handles branch/jump redirects at any point in the fetch lifecycle.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   redirect_valid/_target         taken branch/jump resolution
//   imem_req_valid/_ready/_addr    fetch request handshake
//   imem_resp_valid/_data          response pulse for the oldest request
//   id_valid/_ready/_pc/_inst      instruction handoff to decode
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst
);

    // REQ : request on the bus
    // WAIT: request accepted, response will be kept
    // DROP: request accepted but stale, response will be discarded
    // HOLD: instruction buffered for decode
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP, S_HOLD} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic        req_valid_q, id_valid_q;
    logic        req_fire, id_fire;

    // Target low bits are forced to zero, so they are intentionally unused.
    logic unused_tgt_lsb;
    assign unused_tgt_lsb = ^redirect_target[1:0];

    assign req_fire = req_valid_q & imem_req_ready;
    assign id_fire  = id_valid_q & id_ready;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        id_pc_d   = id_pc_q;
        id_inst_d = id_inst_q;

        if (redirect_valid) begin
            pc_d = {redirect_target[31:2], 2'b00};
            unique case (state_q)
                // An accepted request is now stale; its response must be eaten.
                S_REQ:  state_d = req_fire ? S_DROP : S_REQ;
                S_WAIT: state_d = imem_resp_valid ? S_REQ : S_DROP;
                // A response arriving in the same cycle is the one DROP was
                // waiting for, so nothing is outstanding afterwards.
                S_DROP: state_d = imem_resp_valid ? S_REQ : S_DROP;
                // Held instruction is squashed even if decode takes it now.
                S_HOLD: state_d = S_REQ;
                default: state_d = S_REQ;
            endcase
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (req_fire) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        id_pc_d   = pc_q;
                        id_inst_d = imem_resp_data;
                        pc_d      = pc_q + 32'd4;  // wraps modulo 2^32
                        state_d   = S_HOLD;
                    end
                end
                S_DROP: begin
                    if (imem_resp_valid) state_d = S_REQ;
                end
                S_HOLD: begin
                    if (id_fire) state_d = S_REQ;
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    // Handshake valids are registered copies of the next-state decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            id_pc_q     <= 32'h0;
            id_inst_q   <= 32'h0;
            req_valid_q <= 1'b1;
            id_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            id_pc_q     <= id_pc_d;
            id_inst_q   <= id_inst_d;
            req_valid_q <= (state_d == S_REQ);
            id_valid_q  <= (state_d == S_HOLD);
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = pc_q;
    assign id_valid       = id_valid_q;
    assign id_pc          = id_pc_q;
    assign id_inst        = id_inst_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed vector table covering fetch, stall and all
// redirect cases, a mid-transaction reset, then a randomized run against a
// memory model with a scoreboard of expected decode handoffs.
module tb_ifu_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req_ready, imem_resp_valid, id_ready;
    logic [31:0] imem_resp_data;
    logic        req_valid, id_valid, u1_req_valid, u1_id_valid;
    logic [31:0] req_addr, id_pc, id_inst, u1_req_addr, u1_id_pc, u1_id_inst;

    always #5 clk = ~clk;

    ifu_fetch u0 (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .imem_req_valid(req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_inst(id_inst)
    );

    ifu_fetch #(.RESET_PC(32'hFFFF_FFFC)) u1 (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .imem_req_valid(u1_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(u1_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .id_valid(u1_id_valid), .id_ready(id_ready), .id_pc(u1_id_pc), .id_inst(u1_id_inst)
    );

    typedef struct packed {
        logic        rv;
        logic [31:0] tgt;
        logic        rdy;
        logic        rsp;
        logic [31:0] rdata;
        logic        idr;
        logic        erqv;
        logic [31:0] eaddr;
        logic        eidv;
        logic [31:0] epc;
        logic [31:0] einst;
    } vec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } sb_t;

    vec_t vq[$];
    sb_t  sb[$];
    int   compared = 0;
    int   mismatched = 0;

    function automatic void add(input logic rv, input logic [31:0] tgt,
                                input logic rdy, input logic rsp,
                                input logic [31:0] rdata, input logic idr,
                                input logic erqv, input logic [31:0] eaddr,
                                input logic eidv, input logic [31:0] epc,
                                input logic [31:0] einst);
        vec_t v;
        v = '{rv, tgt, rdy, rsp, rdata, idr, erqv, eaddr, eidv, epc, einst};
        vq.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic drive(input logic rv, input logic [31:0] tgt, input logic rdy,
                         input logic rsp, input logic [31:0] rdata, input logic idr);
        redirect_valid  = rv;
        redirect_target = tgt;
        imem_req_ready  = rdy;
        imem_resp_valid = rsp;
        imem_resp_data  = rdata;
        id_ready        = idr;
    endtask

    initial begin
        logic        pending, was_pending;
        int          lat, ids;
        logic [31:0] p_addr, exp_addr;
        sb_t         e;

        // rv  tgt            rdy rsp rdata          idr  erqv eaddr          eidv epc            einst
        add(0, 32'h0,          1, 0, 32'h0,          0,   1, 32'h8000_0000, 0, 32'h0,          32'h0);
        add(0, 32'h0,          0, 1, 32'h0000_0013,  0,   0, 32'h0,         0, 32'h0,          32'h0);
        add(0, 32'h0,          0, 0, 32'h0,          1,   0, 32'h0,         1, 32'h8000_0000,  32'h0000_0013);
        add(0, 32'h0,          0, 0, 32'h0,          0,   1, 32'h8000_0004, 0, 32'h0,          32'h0);
        add(0, 32'h0,          1, 0, 32'h0,          0,   1, 32'h8000_0004, 0, 32'h0,          32'h0);
        add(0, 32'h0,          0, 1, 32'h0010_0093,  0,   0, 32'h0,         0, 32'h0,          32'h0);
        for (int k = 0; k < 5; k++)
            add(0, 32'h0,      0, 0, 32'h0,          0,   0, 32'h0,         1, 32'h8000_0004,  32'h0010_0093);
        add(0, 32'h0,          0, 0, 32'h0,          1,   0, 32'h0,         1, 32'h8000_0004,  32'h0010_0093);
        add(0, 32'h0,          1, 0, 32'h0,          0,   1, 32'h8000_0008, 0, 32'h0,          32'h0);
        add(1, 32'h8000_0102,  0, 0, 32'h0,          0,   0, 32'h0,         0, 32'h0,          32'h0);
        add(0, 32'h0,          0, 0, 32'h0,          0,   0, 32'h0,         0, 32'h0,          32'h0);
        add(0, 32'h0,          0, 1, 32'hDEAD_BEEF,  0,   0, 32'h0,         0, 32'h0,          32'h0);
        add(1, 32'h8000_0010,  0, 0, 32'h0,          0,   1, 32'h8000_0100, 0, 32'h0,          32'h0);
        add(1, 32'h8000_0200,  1, 0, 32'h0,          0,   1, 32'h8000_0010, 0, 32'h0,          32'h0);
        add(0, 32'h0,          0, 1, 32'hBAD0_BAD0,  0,   0, 32'h0,         0, 32'h0,          32'h0);
        add(0, 32'h0,          1, 0, 32'h0,          0,   1, 32'h8000_0200, 0, 32'h0,          32'h0);
        add(0, 32'h0,          0, 1, 32'h0000_0011,  0,   0, 32'h0,         0, 32'h0,          32'h0);
        add(1, 32'h8000_0300,  0, 0, 32'h0,          1,   0, 32'h0,         1, 32'h8000_0200,  32'h0000_0011);
        add(0, 32'h0,          1, 0, 32'h0,          0,   1, 32'h8000_0300, 0, 32'h0,          32'h0);
        add(1, 32'h8000_0400,  0, 1, 32'h0000_0022,  0,   0, 32'h0,         0, 32'h0,          32'h0);
        add(0, 32'h0,          1, 0, 32'h0,          0,   1, 32'h8000_0400, 0, 32'h0,          32'h0);
        add(1, 32'h8000_0500,  0, 0, 32'h0,          0,   0, 32'h0,         0, 32'h0,          32'h0);
        add(1, 32'h8000_0600,  0, 0, 32'h0,          0,   0, 32'h0,         0, 32'h0,          32'h0);
        add(0, 32'h0,          0, 1, 32'h0,          0,   0, 32'h0,         0, 32'h0,          32'h0);
        add(0, 32'h0,          0, 0, 32'h0,          0,   1, 32'h8000_0600, 0, 32'h0,          32'h0);

        // Reset state
        rst = 1'b1;
        drive(1, 32'h1234_5678, 1, 0, 32'h0, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("reset req_valid", req_valid, 1);
        chk("reset req_addr", req_addr, 32'h8000_0000);
        chk("reset id_valid", id_valid, 0);
        chk("reset id_pc", id_pc, 0);
        chk("reset id_inst", id_inst, 0);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rv, vq[i].tgt, vq[i].rdy, vq[i].rsp, vq[i].rdata, vq[i].idr);
            #1;
            chk($sformatf("row%0d req_valid", i), req_valid, vq[i].erqv);
            if (vq[i].erqv) chk($sformatf("row%0d req_addr", i), req_addr, vq[i].eaddr);
            chk($sformatf("row%0d id_valid", i), id_valid, vq[i].eidv);
            if (vq[i].eidv) begin
                chk($sformatf("row%0d id_pc", i), id_pc, vq[i].epc);
                chk($sformatf("row%0d id_inst", i), id_inst, vq[i].einst);
            end
            if (i == 0) chk("wrap first addr", u1_req_addr, 32'hFFFF_FFFC);
            if (i == 2) chk("wrap id_pc", u1_id_pc, 32'hFFFF_FFFC);
            if (i == 3) chk("wrap next addr", u1_req_addr, 32'h0000_0000);
            @(posedge clk);
            #1;
        end

        // Reset while a request is outstanding; reset beats a redirect.
        drive(0, 32'h0, 1, 0, 32'h0, 0);
        @(posedge clk); #1;
        chk("midrst in WAIT", req_valid, 0);
        rst = 1'b1;
        drive(1, 32'h8000_0900, 0, 0, 32'h0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 32'h0, 0, 0, 32'h0, 0);
        #1;
        chk("midrst req_valid", req_valid, 1);
        chk("midrst req_addr", req_addr, 32'h8000_0000);
        chk("midrst id_valid", id_valid, 0);

        // Randomized run: memory model with 1..3 cycle latency, scoreboard
        // of expected {pc, inst} pushed when a request is accepted.
        pending  = 1'b0;
        lat      = 0;
        ids      = 0;
        p_addr   = 32'h0;
        exp_addr = 32'h8000_0000;
        for (int c = 0; c < 400; c++) begin
            was_pending = pending;
            drive(0, 32'h0, 1'($urandom_range(0, 1)), 0, 32'h0,
                  1'($urandom_range(0, 3) != 0));
            if (pending && lat == 0) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = memf(p_addr);
                pending         = 1'b0;
            end else if (pending) begin
                lat--;
            end
            #1;
            chk($sformatf("cyc%0d valids exclusive", c), req_valid & id_valid, 0);
            if (req_valid && imem_req_ready) begin
                chk($sformatf("cyc%0d one outstanding", c), was_pending, 0);
                chk($sformatf("cyc%0d fetch addr", c), req_addr, exp_addr);
                sb.push_back('{exp_addr, memf(exp_addr)});
                exp_addr = exp_addr + 32'd4;
                p_addr   = req_addr;
                pending  = 1'b1;
                lat      = $urandom_range(0, 2);
            end
            if (id_valid && id_ready) begin
                ids++;
                if (sb.size() == 0) begin
                    chk($sformatf("cyc%0d unexpected id fire", c), 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("cyc%0d sb id_pc", c), id_pc, e.pc);
                    chk($sformatf("cyc%0d sb id_inst", c), id_inst, e.inst);
                end
            end
            @(posedge clk);
            #1;
        end
        chk("random throughput", 32'(ids >= 20), 1);
        chk("scoreboard drained", 32'(sb.size() <= 1), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
